// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift-and-subtract divider: default width,
// FSM state encoding and counter width.
package shift_sub_divider_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int COUNT_W        = $clog2(DEF_DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_D = 2'd1,
      CALC   = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Operand/result handshake bundle shared by the divider and its data-bus master.
interface shift_sub_divider_if
   import shift_sub_divider_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;
   logic                  div_by_zero;
   logic                  busy;

   modport master (
      output in_valid, data_in, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
   );

   modport slave (
      input  in_valid, data_in, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, busy
   );

endinterface

// File: rtl/shift_sub_divider_sub_d_rem.sv
// Trial subtraction {REM, Q[MSB]} - D, one bit wider than the operands so the
// top bit of the difference is the borrow (the shifted remainder is < 2*D).
module shift_sub_divider_sub_d_rem #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] rem,
   input  logic                  q_msb,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] diff,
   output logic                  borrow
);

   logic [DATA_WIDTH:0] t;

   // widened subtraction; MSB set means the divisor did not fit
   always_comb begin
      t = {rem, q_msb} - {1'b0, d};
   end

   assign diff   = t[DATA_WIDTH-1:0];
   assign borrow = t[DATA_WIDTH];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: dividend beat then divisor beat on data_in,
// one quotient bit per clock, registered quotient/remainder with back-pressure.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for dividend beat; in_ready high
//   LOAD_D | dividend held in Q, waiting for divisor beat; in_ready high
//   CALC   | one shift/subtract iteration per clock, count 0..W-1
//   DONE   | result presented with out_valid until out_ready
module shift_sub_divider
   import shift_sub_divider_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   shift_sub_divider_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

   state_t                 state;
   logic [DATA_WIDTH-1:0]  q_r;
   logic [DATA_WIDTH-1:0]  rem_r;
   logic [DATA_WIDTH-1:0]  d_r;
   logic [CNT_W-1:0]       count;

   logic [DATA_WIDTH-1:0]  quot_r;
   logic [DATA_WIDTH-1:0]  rmd_r;
   logic                   out_valid_r;
   logic                   dbz_r;
   logic                   busy_r;
   logic                   in_ready_r;

   logic [DATA_WIDTH-1:0]  sub_diff;
   logic                   sub_borrow;
   logic [DATA_WIDTH-1:0]  rem_next;
   logic [DATA_WIDTH-1:0]  q_next;
   logic                   in_beat;
   logic                   out_take;

   shift_sub_divider_sub_d_rem #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sub_d_rem (
      .rem    (rem_r),
      .q_msb  (q_r[DATA_WIDTH-1]),
      .d      (d_r),
      .diff   (sub_diff),
      .borrow (sub_borrow)
   );

   assign in_beat  = bus.in_valid & in_ready_r;
   assign out_take = out_valid_r & bus.out_ready;

   // restore on borrow (plain shift), otherwise keep the difference; quotient bit = ~borrow
   always_comb begin
      rem_next = sub_borrow ? {rem_r[DATA_WIDTH-2:0], q_r[DATA_WIDTH-1]} : sub_diff;
      q_next   = {q_r[DATA_WIDTH-2:0], ~sub_borrow};
   end

   // FSM, iteration counter, operand registers and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         q_r         <= '0;
         rem_r       <= '0;
         d_r         <= '0;
         count       <= '0;
         quot_r      <= '0;
         rmd_r       <= '0;
         out_valid_r <= 1'b0;
         dbz_r       <= 1'b0;
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_r <= 1'b1;
               if (in_beat) begin
                  q_r    <= bus.data_in;
                  rem_r  <= '0;
                  busy_r <= 1'b1;
                  state  <= LOAD_D;
               end
            end
            LOAD_D: begin
               if (in_beat) begin
                  d_r        <= bus.data_in;
                  count      <= '0;
                  in_ready_r <= 1'b0;
                  if (bus.data_in == '0) begin
                     quot_r      <= '1;
                     rmd_r       <= q_r;
                     dbz_r       <= 1'b1;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_next;
               q_r   <= q_next;
               count <= count + 1'b1;
               if (count == LAST_CNT) begin
                  quot_r      <= q_next;
                  rmd_r       <= rem_next;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_take) begin
                  out_valid_r <= 1'b0;
                  dbz_r       <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.quotient    = quot_r;
   assign bus.remainder   = rmd_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.busy        = busy_r;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: expected results are queued when
// operands are driven and popped when the divider hands back a result.
module tb_shift_sub_divider;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } res_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   res_t exp_q[$];

   shift_sub_divider_if #(.DATA_WIDTH(8)) bus ();

   shift_sub_divider #(.DATA_WIDTH(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
      res_t m;
      if (b == 8'd0) begin
         m.q = 8'hFF; m.r = a; m.dz = 1'b1;
      end else begin
         m.q = a / b; m.r = a % b; m.dz = 1'b0;
      end
      return m;
   endfunction

   // offer one beat starting at a negedge; returns at the negedge after acceptance
   task automatic send_beat(input logic [7:0] v, output bit ok);
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.data_in  = v;
      for (int i = 0; i < 64; i++) begin
         if (bus.in_ready) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_div(input logic [7:0] a, input logic [7:0] b, output bit ok);
      bit ok1, ok2;
      send_beat(a, ok1);
      send_beat(b, ok2);
      ok = ok1 & ok2;
   endtask

   // wait for out_valid (counting negedges), then take the result
   task automatic get_result(output res_t got, output int lat, output bit ok);
      ok = 1'b0; lat = 0; got = '0;
      for (int i = 0; i < 64; i++) begin
         if (bus.out_valid) begin
            got.q  = bus.quotient;
            got.r  = bus.remainder;
            got.dz = bus.div_by_zero;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.div_by_zero, bus.busy, bus.in_ready} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags got ov/dz/busy/rdy=%b want 0000",
                  {bus.out_valid, bus.div_by_zero, bus.busy, bus.in_ready});
      end
      vectors++;
      if ({bus.quotient, bus.remainder} !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_result got q=%0d r=%0d want 0/0", bus.quotient, bus.remainder);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_basic();
      res_t got, exp;
      int   lat;
      bit   ok, okr;
      exp_q.push_back('{q: 8'd14, r: 8'd2, dz: 1'b0});
      run_div(8'd100, 8'd7, ok);
      vectors++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
      end
      get_result(got, lat, okr);
      exp = exp_q.pop_front();
      vectors++;
      if (!ok || !okr || got !== exp) begin
         miscompares++;
         $display("FAIL basic_100_7 got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b (ok=%b/%b)",
                  got.q, got.r, got.dz, exp.q, exp.r, exp.dz, ok, okr);
      end
      vectors++;
      if (lat !== 8) begin
         miscompares++;
         $display("FAIL basic_latency got %0d want 8", lat);
      end
   endtask

   task automatic test_patterns();
      logic [7:0] pa [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
      logic [7:0] pb [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
      logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd1,   8'd0};
      logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0,   8'd0};
      res_t got, exp;
      int   lat;
      bit   ok, okr;
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{q: eq[k], r: er[k], dz: 1'b0});
         run_div(pa[k], pb[k], ok);
         get_result(got, lat, okr);
         exp = exp_q.pop_front();
         vectors++;
         if (!ok || !okr || got !== exp) begin
            miscompares++;
            $display("FAIL pattern_%0d_%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     pa[k], pb[k], got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
         end
      end
   endtask

   task automatic test_div_zero();
      res_t got, exp;
      int   lat;
      bit   ok, okr;
      exp_q.push_back('{q: 8'hFF, r: 8'd37, dz: 1'b1});
      run_div(8'd37, 8'd0, ok);
      get_result(got, lat, okr);
      exp = exp_q.pop_front();
      vectors++;
      if (!ok || !okr || got !== exp) begin
         miscompares++;
         $display("FAIL divzero_result got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                  got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
      end
      vectors++;
      if (lat !== 0) begin
         miscompares++;
         $display("FAIL divzero_latency got %0d want 0 extra cycles", lat);
      end
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL divzero_clear got ov=%b dz=%b want 0/0", bus.out_valid, bus.div_by_zero);
      end
   endtask

   task automatic test_back_pressure();
      res_t exp;
      bit   ok, seen;
      int   bad;
      exp_q.push_back('{q: 8'd15, r: 8'd5, dz: 1'b0});
      run_div(8'd200, 8'd13, ok);
      seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      exp = exp_q.pop_front();
      vectors++;
      if (!ok || !seen) begin
         miscompares++;
         $display("FAIL bp_wait got ok=%b out_valid_seen=%b want 1/1", ok, seen);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.data_in  = 8'(i + 1);
         @(negedge clk);
         vectors++;
         if ({bus.quotient, bus.remainder, bus.div_by_zero} !== exp ||
             bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            bad++;
            if (bad < 4)
               $display("FAIL bp_hold cycle %0d got q=%0d r=%0d ov=%b rdy=%b want q=%0d r=%0d ov=1 rdy=0",
                        i, bus.quotient, bus.remainder, bus.out_valid, bus.in_ready, exp.q, exp.r);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release got ov=%b rdy=%b busy=%b want 0/1/0",
                  bus.out_valid, bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_reset_mid_calc();
      res_t got, exp;
      int   lat;
      bit   ok, okr;
      run_div(8'd100, 8'd7, ok);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.out_valid, bus.div_by_zero, bus.busy, bus.in_ready,
           bus.quotient, bus.remainder} !== 20'h0) begin
         miscompares++;
         $display("FAIL midreset_outputs got ov=%b dz=%b busy=%b rdy=%b q=%0d r=%0d want all 0",
                  bus.out_valid, bus.div_by_zero, bus.busy, bus.in_ready,
                  bus.quotient, bus.remainder);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_ready got %b want 1", bus.in_ready);
      end
      exp_q.push_back('{q: 8'd8, r: 8'd2, dz: 1'b0});
      run_div(8'd50, 8'd6, ok);
      get_result(got, lat, okr);
      exp = exp_q.pop_front();
      vectors++;
      if (!ok || !okr || got !== exp) begin
         miscompares++;
         $display("FAIL midreset_50_6 got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                  got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
      end
   endtask

   task automatic test_random();
      logic [7:0] a, b;
      res_t got, exp;
      bit   ok, taken, rdy_err;
      int   sel, nerr;
      nerr = 0;
      for (int n = 0; n < 3000; n++) begin
         a   = 8'($urandom_range(0, 255));
         sel = int'($urandom_range(0, 15));
         if (sel == 0)     b = 8'd0;
         else if (sel < 5) b = 8'($urandom_range(1, 15));
         else              b = 8'($urandom_range(1, 255));
         exp_q.push_back(model(a, b));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_div(a, b, ok);
         taken = 1'b0; rdy_err = 1'b0; got = '0;
         for (int i = 0; i < 200; i++) begin
            if (bus.in_ready) rdy_err = 1'b1;
            if (bus.out_valid && $urandom_range(0, 1) == 1) begin
               got.q  = bus.quotient;
               got.r  = bus.remainder;
               got.dz = bus.div_by_zero;
               bus.in_valid  = 1'b0;
               bus.out_ready = 1'b1;
               @(negedge clk);
               bus.out_ready = 1'b0;
               taken = 1'b1;
               break;
            end
            bus.in_valid = $urandom_range(0, 1) == 1;
            bus.data_in  = 8'($urandom);
            @(negedge clk);
         end
         bus.in_valid = 1'b0;
         exp = exp_q.pop_front();
         vectors++;
         if (!ok || !taken) begin
            miscompares++;
            $display("FAIL rand_timeout pair %0d/%0d got ok=%b taken=%b want 1/1", a, b, ok, taken);
            return;
         end
         vectors++;
         if (got !== exp) begin
            miscompares++;
            nerr++;
            if (nerr < 6)
               $display("FAIL rand_result %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                        a, b, got.q, got.r, got.dz, exp.q, exp.r, exp.dz);
         end
         vectors++;
         if (rdy_err) begin
            miscompares++;
            $display("FAIL rand_busy_ready %0d/%0d got in_ready=1 while busy want 0", a, b);
         end
         if (b != 8'd0) begin
            vectors++;
            if ((int'(got.q) * int'(b) + int'(got.r)) != int'(a) || got.r >= b) begin
               miscompares++;
               $display("FAIL rand_invariant %0d/%0d got q=%0d r=%0d want q*b+r=a, r<b",
                        a, b, got.q, got.r);
            end
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.data_in = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_patterns();
      test_div_zero();
      test_back_pressure();
      test_reset_mid_calc();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no completion want finish before 5ms");
      $fatal(1, "watchdog expired");
   end

endmodule
